// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter running uninterruptible bursts from two requesters on one SRAM macro
module sram_arbiter (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        REQ_M0,
  input  logic        WE_M0,
  input  logic [31:0] ADDR_M0,
  input  logic [3:0]  LEN_M0,
  input  logic [31:0] WDATA_M0,
  input  logic [3:0]  WSTRB_M0,
  output logic        GNT_M0,
  output logic        WREADY_M0,
  output logic        RVALID_M0,
  output logic [31:0] RDATA_M0,
  output logic        DONE_M0,
  input  logic        REQ_M1,
  input  logic        WE_M1,
  input  logic [31:0] ADDR_M1,
  input  logic [3:0]  LEN_M1,
  input  logic [31:0] WDATA_M1,
  input  logic [3:0]  WSTRB_M1,
  output logic        GNT_M1,
  output logic        WREADY_M1,
  output logic        RVALID_M1,
  output logic [31:0] RDATA_M1,
  output logic        DONE_M1,
  output logic [13:0] SRAM_A,
  output logic [31:0] SRAM_DI,
  input  logic [31:0] SRAM_DO,
  output logic [3:0]  SRAM_WEB,
  output logic        SRAM_OE,
  output logic        SRAM_CS
);
  localparam logic [1:0] IDLE = 2'd0, BURST = 2'd1, DRAIN = 2'd2;
  logic [1:0] state;
  logic owner, ptr, we;
  logic [13:0] base;
  logic [3:0] len, cnt;
  logic idle, burst, drain, pick1, wr, rvalid, done;
  logic unused_addr;
  assign idle = state == IDLE;
  assign burst = state == BURST;
  assign drain = state == DRAIN;
  assign pick1 = REQ_M1 & (~REQ_M0 | ptr);
  assign GNT_M0 = idle & REQ_M0 & ~pick1;
  assign GNT_M1 = idle & pick1;
  always_ff @(posedge ACLK)
    if (ARESET) begin
      state <= IDLE;
      owner <= 1'b0;
      ptr <= 1'b0;
      we <= 1'b0;
      base <= 14'd0;
      len <= 4'd0;
      cnt <= 4'd0;
    end else if (idle) begin
      if (REQ_M0 | REQ_M1) begin
        state <= BURST;
        owner <= pick1;
        ptr <= ~pick1;
        we <= pick1 ? WE_M1 : WE_M0;
        base <= pick1 ? ADDR_M1[15:2] : ADDR_M0[15:2];
        len <= pick1 ? LEN_M1 : LEN_M0;
        cnt <= 4'd0;
      end
    end else if (burst) begin
      cnt <= cnt + 4'd1;
      if (cnt == len) state <= we ? IDLE : DRAIN;
    end else state <= IDLE;
  assign wr = burst & we;
  assign rvalid = drain | (burst & ~we & (cnt != 4'd0));
  assign done = drain | (wr & (cnt == len));
  assign WREADY_M0 = wr & ~owner;
  assign WREADY_M1 = wr & owner;
  assign RVALID_M0 = rvalid & ~owner;
  assign RVALID_M1 = rvalid & owner;
  assign RDATA_M0 = RVALID_M0 ? SRAM_DO : 32'd0;
  assign RDATA_M1 = RVALID_M1 ? SRAM_DO : 32'd0;
  assign DONE_M0 = done & ~owner;
  assign DONE_M1 = done & owner;
  assign SRAM_CS = burst | drain;
  assign SRAM_OE = drain | (burst & ~we);
  assign SRAM_WEB = wr ? ~(owner ? WSTRB_M1 : WSTRB_M0) : 4'hF;
  assign SRAM_DI = wr ? (owner ? WDATA_M1 : WDATA_M0) : 32'd0;
  assign SRAM_A = SRAM_CS ? base + {10'd0, drain ? len : cnt} : 14'd0;
  assign unused_addr = ^{ADDR_M0[31:16], ADDR_M0[1:0], ADDR_M1[31:16], ADDR_M1[1:0]};
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized scoreboard bench for sram_arbiter with a behavioural SRAM and reference memory
module tb_sram_arbiter;
  typedef struct packed {
    logic we;
    logic [31:0] addr;
    logic [3:0] len;
    logic [15:0][31:0] wd;
    logic [15:0][3:0] ws;
    logic [7:0] gap;
  } cmd_t;
  typedef struct packed {
    int cyc;
    logic rd;
    logic m;
    logic last;
    logic [13:0] a;
    logic [31:0] d;
    logic [3:0] web;
  } exp_t;
  typedef struct packed {
    int cyc;
    logic [13:0] a;
  } ad_t;
  logic clk, ARESET;
  logic [1:0] req, we_in, gnt, wready, rvalid, done, busy;
  logic [31:0] addr_in [2];
  logic [3:0] len_in [2];
  logic [31:0] wdata_in [2];
  logic [3:0] wstrb_in [2];
  logic [31:0] rdata [2];
  logic [13:0] SRAM_A;
  logic [31:0] SRAM_DI, SRAM_DO;
  logic [3:0] SRAM_WEB;
  logic SRAM_OE, SRAM_CS;
  logic [31:0] mem [16384];
  logic [31:0] ref_mem [16384];
  cmd_t cq [2][$];
  cmd_t cur [2];
  exp_t dq [$];
  ad_t aq [$];
  int cyc = 0, free_cyc = 0, total = 0, bad = 0;
  logic ptr_m = 1'b0, started = 1'b0;
  sram_arbiter dut (
    .ACLK(clk), .ARESET(ARESET),
    .REQ_M0(req[0]), .WE_M0(we_in[0]), .ADDR_M0(addr_in[0]), .LEN_M0(len_in[0]),
    .WDATA_M0(wdata_in[0]), .WSTRB_M0(wstrb_in[0]), .GNT_M0(gnt[0]), .WREADY_M0(wready[0]),
    .RVALID_M0(rvalid[0]), .RDATA_M0(rdata[0]), .DONE_M0(done[0]),
    .REQ_M1(req[1]), .WE_M1(we_in[1]), .ADDR_M1(addr_in[1]), .LEN_M1(len_in[1]),
    .WDATA_M1(wdata_in[1]), .WSTRB_M1(wstrb_in[1]), .GNT_M1(gnt[1]), .WREADY_M1(wready[1]),
    .RVALID_M1(rvalid[1]), .RDATA_M1(rdata[1]), .DONE_M1(done[1]),
    .SRAM_A(SRAM_A), .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO), .SRAM_WEB(SRAM_WEB),
    .SRAM_OE(SRAM_OE), .SRAM_CS(SRAM_CS)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (SRAM_CS && SRAM_OE) SRAM_DO <= mem[SRAM_A];
    for (int b = 0; b < 4; b++)
      if (SRAM_CS && !SRAM_WEB[b]) mem[SRAM_A][8*b +: 8] <= SRAM_DI[8*b +: 8];
  end
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%h expected=%h", n, cyc, act, exp);
    end
  endtask
  task automatic push(input int m, input logic w, input logic [31:0] a, input logic [3:0] l,
                      input logic [15:0][31:0] wd, input logic [15:0][3:0] ws, input logic [7:0] g);
    cmd_t c;
    c.we = w;
    c.addr = a;
    c.len = l;
    c.wd = wd;
    c.ws = ws;
    c.gap = g;
    cq[m].push_back(c);
  endtask
  task automatic rnd_push(input int m);
    logic [15:0][31:0] wd;
    logic [15:0][3:0] ws;
    for (int i = 0; i < 16; i++) begin
      wd[i] = $urandom;
      ws[i] = 4'($urandom_range(0, 15));
    end
    push(m, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), wd, ws, 8'($urandom_range(0, 3)));
  endtask
  task automatic drive(input int m);
    cmd_t c;
    int n;
    forever begin
      @(posedge clk);
      #1;
      if (cq[m].size() != 0) begin
        busy[m] = 1'b1;
        c = cq[m].pop_front();
        repeat (c.gap) begin
          @(posedge clk);
          #1;
        end
        cur[m] = c;
        we_in[m] = c.we;
        addr_in[m] = c.addr;
        len_in[m] = c.len;
        req[m] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!gnt[m] && n < 400) begin
          @(negedge clk);
          n++;
        end
        chk("gnt_wait", 128'(gnt[m]), 128'd1);
        for (int i = 0; i <= int'(c.len); i++) begin
          @(posedge clk);
          #1;
          req[m] = 1'b0;
          wdata_in[m] = c.wd[i];
          wstrb_in[m] = c.ws[i];
        end
        busy[m] = 1'b0;
      end
    end
  endtask
  task automatic mon();
    exp_t e;
    ad_t d;
    logic [1:0] eg;
    logic w, hit;
    logic [5:0] beats;
    logic [13:0] a, ai;
    eg = 2'b00;
    w = (req == 2'b11) ? ptr_m : req[1];
    if (cyc >= free_cyc && req != 2'b00) eg = w ? 2'b10 : 2'b01;
    chk("gnt", 128'(gnt), 128'(eg));
    if (eg != 2'b00) begin
      a = addr_in[w][15:2];
      for (int i = 0; i <= int'(len_in[w]); i++) begin
        ai = a + 14'(i);
        e.rd = ~we_in[w];
        e.m = w;
        e.last = i == int'(len_in[w]);
        e.a = ai;
        if (we_in[w]) begin
          e.cyc = cyc + 1 + i;
          e.d = cur[w].wd[i];
          e.web = ~cur[w].ws[i];
          for (int b = 0; b < 4; b++)
            if (cur[w].ws[i][b]) ref_mem[ai][8*b +: 8] = e.d[8*b +: 8];
        end else begin
          d.cyc = cyc + 1 + i;
          d.a = ai;
          aq.push_back(d);
          e.cyc = cyc + 2 + i;
          e.d = ref_mem[ai];
          e.web = 4'hF;
        end
        dq.push_back(e);
      end
      ptr_m = ~w;
      free_cyc = cyc + int'(len_in[w]) + (we_in[w] ? 2 : 3);
    end
    beats = {wready, rvalid, done};
    hit = 1'b0;
    if (aq.size() != 0 && aq[0].cyc == cyc) begin
      d = aq.pop_front();
      hit = 1'b1;
      chk("rd_addr", 128'({SRAM_CS, SRAM_OE, SRAM_WEB, SRAM_A}), 128'({2'b11, 4'hF, d.a}));
    end
    if (dq.size() != 0 && dq[0].cyc == cyc) begin
      e = dq.pop_front();
      hit = 1'b1;
      if (e.rd) begin
        chk("rd_beat", 128'(beats), 128'({2'b00, e.m, ~e.m, e.last & e.m, e.last & ~e.m}));
        chk("rdata", 128'({rdata[1], rdata[0]}), e.m ? 128'({e.d, 32'd0}) : 128'({32'd0, e.d}));
        if (e.last) chk("drain_bus", 128'({SRAM_CS, SRAM_OE, SRAM_WEB, SRAM_A}), 128'({2'b11, 4'hF, e.a}));
      end else begin
        chk("wr_beat", 128'(beats), 128'({e.m, ~e.m, 2'b00, e.last & e.m, e.last & ~e.m}));
        chk("wr_bus", 128'({SRAM_CS, SRAM_OE, SRAM_WEB, SRAM_A, SRAM_DI}), 128'({2'b10, e.web, e.a, e.d}));
      end
    end else if (hit) chk("no_beat", 128'(beats), 128'd0);
    if (!hit)
      chk("idle_bus", {6'd0, SRAM_CS, SRAM_OE, SRAM_WEB, SRAM_A, SRAM_DI, rdata[1], rdata[0], beats},
          {6'd0, 2'b00, 4'hF, 14'd0, 32'd0, 64'd0, 6'd0});
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((cq[0].size() != 0 || cq[1].size() != 0 || dq.size() != 0 || aq.size() != 0 || busy != 2'b00) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("idle_timeout", 128'(n < 3000), 128'd1);
    repeat (2) @(posedge clk);
  endtask
  initial drive(0);
  initial drive(1);
  initial forever begin
    @(negedge clk);
    if (started) mon();
  end
  initial begin
    logic [15:0][31:0] wd;
    logic [15:0][3:0] ws;
    logic [31:0] v;
    int n;
    ARESET = 1'b1;
    req = 2'b00;
    busy = 2'b00;
    for (int m = 0; m < 2; m++) begin
      we_in[m] = 1'b0;
      addr_in[m] = 32'd0;
      len_in[m] = 4'd0;
      wdata_in[m] = 32'd0;
      wstrb_in[m] = 4'd0;
    end
    for (int i = 0; i < 16384; i++) begin
      v = 32'hC3A5_0000 ^ (i * 32'h9E37_79B1);
      mem[i] = v;
      ref_mem[i] = v;
    end
    for (int i = 0; i < 4; i++) begin
      mem[64 + i] = 32'hA0 + i;
      ref_mem[64 + i] = 32'hA0 + i;
    end
    wd = '0;
    ws = '0;
    repeat (3) @(posedge clk);
    #1;
    ARESET = 1'b0;
    free_cyc = cyc;
    started = 1'b1;
    push(0, 1'b0, 32'h0000_0100, 4'd3, wd, ws, 8'd0);
    wait_idle();
    wd[0] = 32'h1122_3344;
    wd[1] = 32'h5566_7788;
    ws[0] = 4'b1111;
    ws[1] = 4'b0011;
    push(1, 1'b1, 32'h0000_0008, 4'd1, wd, ws, 8'd0);
    wait_idle();
    push(0, 1'b0, 32'h0000_000C, 4'd0, wd, ws, 8'd0);
    push(1, 1'b0, 32'h0000_FFF8, 4'd3, wd, ws, 8'd2);
    wait_idle();
    for (int k = 0; k < 4; k++) begin
      push(0, 1'b0, 32'h0000_0100, 4'(k), wd, ws, 8'd0);
      push(1, 1'b1, 32'h0000_4000 + 32'(k * 64), 4'(k + 1), wd, ws, 8'd0);
    end
    wait_idle();
    for (int k = 0; k < 25; k++) begin
      rnd_push(0);
      rnd_push(1);
    end
    wait_idle();
    push(0, 1'b1, 32'h0000_C000, 4'd7, wd, ws, 8'd0);
    n = 0;
    @(negedge clk);
    while (!gnt[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_burst_gnt", 128'(gnt[0]), 128'd1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    ARESET = 1'b1;
    @(posedge clk);
    #1;
    ARESET = 1'b0;
    dq.delete();
    aq.delete();
    ptr_m = 1'b0;
    free_cyc = cyc;
    repeat (12) @(posedge clk);
    push(1, 1'b0, 32'h0000_0200, 4'd1, wd, ws, 8'd0);
    push(0, 1'b0, 32'h0000_0100, 4'd0, wd, ws, 8'd0);
    n = 0;
    @(negedge clk);
    while (gnt == 2'b00 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("post_rst_first_gnt", 128'(gnt), 128'(2'b01));
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
